commit_trace_buffer: RTL and testbench
======================================

// Module: commit_trace_buffer
// PURPOSE
//   Receives the CPU commit stream (commit, instr, pc, pre_pc) from the pipeline top.
//   Tags each retired instruction with a sequence number and buffers it in a FWFT FIFO.
//   Drains entries to a host/debug reader over a valid/ready handshake.
//   Counts dropped commits and detects the halting ebreak so the testbench knows when a run has ended.
// PARAMETERS
//   DEPTH    16  FIFO entries; power of two, >=2
//   SEQ_W    32  width of sequence/commit counter
//   DROP_W   16  width of saturating drop counter
// PORTS
//   clk              in   1       clock, rising edge
//   rst              in   1       asynchronous, active-low reset
//   trace_en         in   1       1 = capture commits
//   commit           in   1       one-cycle pulse per retired instruction
//   commit_instr     in   32      retired instruction word
//   commit_pc        in   64      PC of retired instruction
//   commit_pre_pc    in   64      pre_pc field of retired instruction
//   trace_o_valid    out  1       head entry available
//   trace_i_ready    in   1       reader accepts head entry this cycle
//   trace_o_instr    out  32      head entry instr
//   trace_o_pc       out  64      head entry pc
//   trace_o_pre_pc   out  64      head entry pre_pc
//   trace_o_seq      out  SEQ_W   head entry sequence number
//   trace_o_level    out  log2(DEPTH)+1  current occupancy
//   commit_cnt       out  SEQ_W   total commit pulses since reset (wraps)
//   drop_cnt         out  DROP_W  commits lost to a full FIFO (saturates at all-ones)
//   overflow         out  1       sticky: any drop since reset
//   halted           out  1       sticky: ebreak captured and FIFO fully drained
// BEHAVIOUR
//   Reset (rst=0, async):
//     - FIFO is empty and all counters are 0; overflow=0, halted=0, trace_o_valid=0.
//     - trace_o_* data outputs are 0. State = IDLE.
//   commit_cnt:
//     - Increments on every commit pulse in every state, wrapping at 2^SEQ_W.
//     - Entry seq = commit_cnt value before that increment, so the first commit has seq 0.
//     - A gap in seq seen by the reader marks dropped or uncaptured commits.
//   State machine (registered):
//     - IDLE:    no capture. -> RUN when trace_en=1.
//     - RUN:     capture. -> IDLE when trace_en=0; -> HALTING when an accepted push has instr==32'h0010_0073.
//     - HALTING: no capture; trace_en ignored. -> HALTED when level==0.
//     - HALTED:  halted=1; terminal until reset.
//     - Transitions take effect the cycle after the triggering condition.
//     - The commit that causes RUN->HALTING is itself captured.
//   Capture/push (state RUN and commit=1):
//     - The entry is written if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle.
//     - Otherwise the entry is dropped: drop_cnt+1 (saturating) and overflow<=1.
//     - The ebreak check applies only to written entries.
//   Read/pop:
//     - FWFT: trace_o_valid = (level!=0); trace_o_* show the head combinationally from storage.
//     - Pop when trace_o_valid & trace_i_ready.
//     - valid and data stay stable until popped; ready without valid has no effect.
//   Latency: a commit pushed at edge N shows up as valid after edge N if the FIFO was empty (one-cycle latency).
//   Simultaneous push and pop: level unchanged; pointers wrap modulo DEPTH.
//   Reset mid-operation discards all entries immediately.
// TESTING
//   1. Reset, trace_en=1, 3 commits (pc 0x80000000/04/08), ready=1 -> 3 beats with seq 0,1,2, then valid=0, level=0.
//   2. ready=0, 20 commits with DEPTH=16 -> level=16, drop_cnt=4, overflow=1. Then ready=1 -> 16 beats with seq 0..15.
//   3. FIFO full, commit and pop in the same cycle -> no drop, level stays 16, new entry lands at the tail.
//   4. trace_en=0 during 5 commits, then trace_en=1, 1 commit -> a single entry with seq 5; commit_cnt=6.
//   5. Commit instr 32'h00100073 with 2 entries queued -> HALTING; further commits are not captured.
//      After 3 pops, halted=1 and trace_en toggling has no effect.
//   6. Assert rst=0 with 8 entries queued and drop_cnt=3 -> everything clears without waiting for a clock edge: valid=0, level=0, counters=0, overflow=0.

Source files
------------

// File: rtl/commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : commit_trace_buffer
// Purpose  : Sequence-tags retired instructions into a FWFT trace FIFO and
//            drains them to a debug reader; counts drops, detects halt ebreak.
// Revision : 1.0  initial release
// ============================================================================
module commit_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int SEQ_W  = 32,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_en,
    input  logic                     commit,
    input  logic [31:0]              commit_instr,
    input  logic [63:0]              commit_pc,
    input  logic [63:0]              commit_pre_pc,
    output logic                     trace_o_valid,
    input  logic                     trace_i_ready,
    output logic [31:0]              trace_o_instr,
    output logic [63:0]              trace_o_pc,
    output logic [63:0]              trace_o_pre_pc,
    output logic [SEQ_W-1:0]         trace_o_seq,
    output logic [$clog2(DEPTH):0]   trace_o_level,
    output logic [SEQ_W-1:0]         commit_cnt,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic                     overflow,
    output logic                     halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [1:0]    c_IDLE    = 2'd0;
    localparam logic [1:0]    c_RUN     = 2'd1;
    localparam logic [1:0]    c_HALTING = 2'd2;
    localparam logic [1:0]    c_HALTED  = 2'd3;
    localparam logic [31:0]   c_EBREAK  = 32'h0010_0073;
    localparam logic [LW-1:0] c_FULL    = LW'(DEPTH);

    logic [1:0]        r_state;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic [SEQ_W-1:0]  r_commit_cnt;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              r_overflow;

    logic [31:0]       r_mem_instr  [DEPTH];
    logic [63:0]       r_mem_pc     [DEPTH];
    logic [63:0]       r_mem_pre_pc [DEPTH];
    logic [SEQ_W-1:0]  r_mem_seq    [DEPTH];

    logic w_valid;
    logic w_pop;
    logic w_try;
    logic w_push;
    logic w_drop;

    assign w_valid = (r_level != '0);
    assign w_pop   = w_valid & trace_i_ready;
    assign w_try   = (r_state == c_RUN) & commit;
    // A full FIFO still accepts a commit when the head leaves in the same cycle.
    assign w_push  = w_try & ((r_level < c_FULL) | w_pop);
    assign w_drop  = w_try & ~w_push;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_commit_cnt <= '0;
            r_drop_cnt   <= '0;
            r_overflow   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE:    if (trace_en) r_state <= c_RUN;
                c_RUN: begin
                    if (w_push && (commit_instr == c_EBREAK)) r_state <= c_HALTING;
                    else if (!trace_en)                       r_state <= c_IDLE;
                end
                c_HALTING: if (r_level == '0) r_state <= c_HALTED;
                default:   r_state <= c_HALTED;
            endcase

            if (commit) r_commit_cnt <= r_commit_cnt + SEQ_W'(1);

            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase

            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr]  <= commit_instr;
            r_mem_pc[r_wr_ptr]     <= commit_pc;
            r_mem_pre_pc[r_wr_ptr] <= commit_pre_pc;
            r_mem_seq[r_wr_ptr]    <= r_commit_cnt;
        end
    end

    // Head is gated by valid so an empty FIFO presents zeros, not stale storage.
    assign trace_o_valid  = w_valid;
    assign trace_o_instr  = w_valid ? r_mem_instr[r_rd_ptr]  : '0;
    assign trace_o_pc     = w_valid ? r_mem_pc[r_rd_ptr]     : '0;
    assign trace_o_pre_pc = w_valid ? r_mem_pre_pc[r_rd_ptr] : '0;
    assign trace_o_seq    = w_valid ? r_mem_seq[r_rd_ptr]    : '0;
    assign trace_o_level  = r_level;
    assign commit_cnt     = r_commit_cnt;
    assign drop_cnt       = r_drop_cnt;
    assign overflow       = r_overflow;
    assign halted         = (r_state == c_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_commit_trace_buffer
// Purpose  : Random and directed stimulus against a queue-based trace model.
// Revision : 1.0  initial release
// ============================================================================
module tb_commit_trace_buffer;

    localparam int          DEPTH  = 16;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trace_en = 1'b0;
    logic        commit = 1'b0;
    logic [31:0] commit_instr = '0;
    logic [63:0] commit_pc = '0;
    logic [63:0] commit_pre_pc = '0;
    logic        trace_i_ready = 1'b0;
    logic        trace_o_valid;
    logic [31:0] trace_o_instr;
    logic [63:0] trace_o_pc;
    logic [63:0] trace_o_pre_pc;
    logic [31:0] trace_o_seq;
    logic [4:0]  trace_o_level;
    logic [31:0] commit_cnt;
    logic [15:0] drop_cnt;
    logic        overflow;
    logic        halted;

    always #5 clk = ~clk;

    commit_trace_buffer #(.DEPTH(DEPTH), .SEQ_W(32), .DROP_W(16)) dut (
        .clk(clk), .rst(rst), .trace_en(trace_en), .commit(commit),
        .commit_instr(commit_instr), .commit_pc(commit_pc), .commit_pre_pc(commit_pre_pc),
        .trace_o_valid(trace_o_valid), .trace_i_ready(trace_i_ready),
        .trace_o_instr(trace_o_instr), .trace_o_pc(trace_o_pc), .trace_o_pre_pc(trace_o_pre_pc),
        .trace_o_seq(trace_o_seq), .trace_o_level(trace_o_level),
        .commit_cnt(commit_cnt), .drop_cnt(drop_cnt), .overflow(overflow), .halted(halted)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] pre;
        logic [31:0] seq;
    } ent_t;

    // Reference model: a plain queue plus a capture mode (0 idle, 1 run, 2 draining, 3 halted).
    ent_t        m_q[$];
    int          m_mode;
    logic [31:0] m_cnt;
    logic [15:0] m_drop;
    bit          m_ovf;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_mode = 0;
        m_cnt  = '0;
        m_drop = '0;
        m_ovf  = 1'b0;
    endtask

    task automatic compare_all();
        chk_val("valid", 64'(trace_o_valid), 64'(m_q.size() != 0));
        chk_val("level", 64'(trace_o_level), 64'(m_q.size()));
        if (m_q.size() != 0) begin
            chk_val("instr",  64'(trace_o_instr), 64'(m_q[0].instr));
            chk_val("pc",     trace_o_pc,         m_q[0].pc);
            chk_val("pre_pc", trace_o_pre_pc,     m_q[0].pre);
            chk_val("seq",    64'(trace_o_seq),   64'(m_q[0].seq));
        end else begin
            chk_val("empty_data", {32'(trace_o_instr | trace_o_seq), 32'(trace_o_pc | trace_o_pre_pc)}, 64'h0);
        end
        chk_val("commit_cnt", 64'(commit_cnt), 64'(m_cnt));
        chk_val("drop_cnt",   64'(drop_cnt),   64'(m_drop));
        chk_val("overflow",   64'(overflow),   64'(m_ovf));
        chk_val("halted",     64'(halted),     64'(m_mode == 3));
    endtask

    task automatic step(input bit c, input bit en, input bit rdy, input logic [31:0] ins);
        ent_t e;
        bit   pop;
        bit   cap;
        bit   push;
        int   sz;
        commit        = c;
        trace_en      = en;
        trace_i_ready = rdy;
        commit_instr  = ins;
        commit_pc     = {$urandom, $urandom};
        commit_pre_pc = {$urandom, $urandom};
        e.instr = ins;
        e.pc    = commit_pc;
        e.pre   = commit_pre_pc;
        e.seq   = m_cnt;
        @(posedge clk);
        sz   = m_q.size();
        pop  = (sz > 0) && rdy;
        cap  = (m_mode == 1) && c;
        push = cap && ((sz < DEPTH) || pop);
        case (m_mode)
            0: if (en) m_mode = 1;
            1: if (push && ins == EBREAK) m_mode = 2;
               else if (!en) m_mode = 0;
            2: if (sz == 0) m_mode = 3;
            default: m_mode = 3;
        endcase
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back(e);
        if (c)    m_cnt = m_cnt + 1;
        if (cap && !push) begin
            m_ovf = 1'b1;
            if (m_drop != 16'hFFFF) m_drop = m_drop + 1;
        end
        #1 compare_all();
    endtask

    task automatic do_reset();
        commit = 1'b0; trace_en = 1'b0; trace_i_ready = 1'b0;
        rst = 1'b0;
        model_clear();
        @(posedge clk);
        #1 compare_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] v;
        v = $urandom;
        if (v == EBREAK) v = v ^ 32'h1;
        return v;
    endfunction

    initial begin
        model_clear();

        // 1: three commits streamed straight out
        do_reset();
        step(0, 1, 1, '0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, rnd_instr());
        for (int i = 0; i < 3; i++) step(0, 1, 1, '0);
        chk_val("t1_level", 64'(trace_o_level), 64'd0);

        // 2: overfill with reader stalled
        for (int i = 0; i < 20; i++) step(1, 1, 0, rnd_instr());
        chk_val("t2_level", 64'(trace_o_level), 64'd16);
        chk_val("t2_drop",  64'(drop_cnt), 64'd4);
        chk_val("t2_ovf",   64'(overflow), 64'd1);

        // 3: push and pop together while full
        step(1, 1, 1, rnd_instr());
        chk_val("t3_level", 64'(trace_o_level), 64'd16);
        chk_val("t3_drop",  64'(drop_cnt), 64'd4);
        for (int i = 0; i < 18; i++) step(0, 1, 1, '0);

        // 4: commits while disabled only bump the counter
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, rnd_instr());
        step(0, 1, 0, '0);
        step(1, 1, 0, rnd_instr());
        chk_val("t4_seq",   64'(trace_o_seq), 64'd5);
        chk_val("t4_cnt",   64'(commit_cnt),  64'd6);
        chk_val("t4_level", 64'(trace_o_level), 64'd1);

        // Random traffic with varying reader throughput
        for (int blk = 0; blk < 20; blk++) begin
            int rp;
            rp = $urandom_range(0, 100);
            for (int i = 0; i < 80; i++)
                step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) != 0),
                     ($urandom_range(1, 100) <= rp), rnd_instr());
        end

        // 6: asynchronous reset with entries queued
        do_reset();
        step(0, 1, 0, '0);
        for (int i = 0; i < 19; i++) step(1, 1, 0, rnd_instr());
        for (int i = 0; i < 8; i++)  step(0, 1, 1, '0);
        chk_val("t6_pre_level", 64'(trace_o_level), 64'd8);
        chk_val("t6_pre_drop",  64'(drop_cnt), 64'd3);
        #2 rst = 1'b0;
        model_clear();
        #1;
        chk_val("t6_valid", 64'(trace_o_valid), 64'd0);
        chk_val("t6_level", 64'(trace_o_level), 64'd0);
        chk_val("t6_cnt",   64'(commit_cnt), 64'd0);
        chk_val("t6_drop",  64'(drop_cnt), 64'd0);
        chk_val("t6_ovf",   64'(overflow), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // 5: ebreak captured, then drain to halted
        step(0, 1, 0, '0);
        step(1, 1, 0, rnd_instr());
        step(1, 1, 0, rnd_instr());
        step(1, 1, 0, EBREAK);
        for (int i = 0; i < 3; i++) step(1, 1, 0, rnd_instr());
        chk_val("t5_level", 64'(trace_o_level), 64'd3);
        for (int i = 0; i < 6; i++) step(1'($urandom_range(0, 1)), 1'(i), 1, rnd_instr());
        chk_val("t5_halted", 64'(halted), 64'd1);
        for (int i = 0; i < 4; i++) step(1, 1'(i), 1, rnd_instr());
        chk_val("t5_level_end", 64'(trace_o_level), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
